// File: rtl/irq_pkg.sv
// Shared types and constants for the multi-source interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } irq_state_e;

  localparam logic [31:0] DefVecBase  = 32'h0000_0080;
  localparam int unsigned DefVecShift = 4;

  // Width of the cause index; never narrower than one bit.
  function automatic int unsigned cause_w(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins, plus an any-valid flag.
module irq_prio_enc #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 3
) (
  input  logic [N-1:0]  req,
  output logic [CW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Scan downwards so the lowest set bit is the last assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) idx = CW'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: edge/level capture, masking, fixed priority
// and a request/acknowledge handshake with the multicycle control FSM.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned       N_IRQ     = 8,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE  = ADDR_W'(DefVecBase),
  parameter int unsigned       VEC_SHIFT = DefVecShift,
  parameter logic [N_IRQ-1:0]  EDGE_MODE = {N_IRQ{1'b1}},
  parameter logic [N_IRQ-1:0]  MASK_RST  = {N_IRQ{1'b1}},
  localparam int unsigned      CW        = cause_w(N_IRQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              fetch_bnd,
  input  logic              int_ack,
  input  logic              rfe,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_wdata,
  output logic              int_req,
  output logic [ADDR_W-1:0] vector_addr,
  output logic [ADDR_W-1:0] epc,
  output logic [CW-1:0]     cause,
  output logic [N_IRQ-1:0]  mask_rdata,
  output logic              in_service,
  output logic [N_IRQ-1:0]  pending
);

  irq_state_e        state_q;
  logic              int_req_q;
  logic              ie_q;
  logic [ADDR_W-1:0] epc_q;
  logic [ADDR_W-1:0] vec_q;
  logic [CW-1:0]     cause_q;
  logic [N_IRQ-1:0]  pending_q;
  logic [N_IRQ-1:0]  pending_d;
  logic [N_IRQ-1:0]  mask_q;
  logic [N_IRQ-1:0]  irq_d_q;
  logic [N_IRQ-1:0]  active;
  logic [N_IRQ-1:0]  edge_set;
  logic [N_IRQ-1:0]  clr;
  logic [CW-1:0]     winner;
  logic              any_active;
  logic              take;

  assign active = pending_q & mask_q;

  irq_prio_enc #(
    .N  (N_IRQ),
    .CW (CW)
  ) u_prio_enc (
    .req (active),
    .idx (winner),
    .any (any_active)
  );

  assign take = (state_q == StReq) && int_ack && any_active;

  always_comb begin
    clr = '0;
    if (take && EDGE_MODE[winner]) clr[winner] = 1'b1;
    edge_set  = irq & ~irq_d_q;
    // Set is OR-ed in after the clear so a same-cycle edge survives an ack.
    pending_d = (EDGE_MODE & ((pending_q & ~clr) | edge_set)) | (~EDGE_MODE & irq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      int_req_q <= 1'b0;
      ie_q      <= 1'b1;
      epc_q     <= '0;
      vec_q     <= VEC_BASE;
      cause_q   <= '0;
      pending_q <= '0;
      mask_q    <= MASK_RST;
      irq_d_q   <= '0;
    end else begin
      irq_d_q   <= irq;
      pending_q <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
      case (state_q)
        StIdle: begin
          if (ie_q && any_active && fetch_bnd) begin
            state_q   <= StReq;
            int_req_q <= 1'b1;
          end
        end
        StReq: begin
          if (int_ack) begin
            int_req_q <= 1'b0;
            if (any_active) begin
              epc_q   <= pc_in;
              cause_q <= winner;
              vec_q   <= VEC_BASE + (ADDR_W'(winner) << VEC_SHIFT);
              ie_q    <= 1'b0;
              state_q <= StService;
            end else begin
              state_q <= StIdle;
            end
          end else if (!any_active) begin
            int_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StService: begin
          if (rfe) begin
            ie_q    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign int_req     = int_req_q;
  assign vector_addr = vec_q;
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign mask_rdata  = mask_q;
  assign in_service  = ~ie_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Table-driven bench for irq_ctrl: each row drives one cycle of inputs and the
// values expected after the next rising edge; source 1 is level, the rest edge.
module tb_irq_ctrl;

  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        fb;
    logic        ack;
    logic        rfe;
    logic [31:0] pc;
    logic        mwe;
    logic [7:0]  mwd;
    logic        req;
    logic        svc;
    logic [7:0]  pend;
    logic [7:0]  mask;
    logic [2:0]  cause;
    logic [31:0] epc;
    logic [31:0] vec;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq;
  logic        fetch_bnd;
  logic        int_ack;
  logic        rfe;
  logic [31:0] pc_in;
  logic        mask_we;
  logic [7:0]  mask_wdata;
  logic        int_req;
  logic [31:0] vector_addr;
  logic [31:0] epc;
  logic [2:0]  cause;
  logic [7:0]  mask_rdata;
  logic        in_service;
  logic [7:0]  pending;

  int   passed = 0;
  int   total  = 0;
  int   row    = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  irq_ctrl #(
    .N_IRQ     (8),
    .ADDR_W    (32),
    .VEC_BASE  (32'h0000_0080),
    .VEC_SHIFT (4),
    .EDGE_MODE (8'hFD),
    .MASK_RST  (8'hFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq),
    .fetch_bnd   (fetch_bnd),
    .int_ack     (int_ack),
    .rfe         (rfe),
    .pc_in       (pc_in),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .int_req     (int_req),
    .vector_addr (vector_addr),
    .epc         (epc),
    .cause       (cause),
    .mask_rdata  (mask_rdata),
    .in_service  (in_service),
    .pending     (pending)
  );

  function automatic vec_t mk(logic r, logic [7:0] i, logic f, logic a, logic e,
                              logic [31:0] p, logic mw, logic [7:0] md, logic q,
                              logic s, logic [7:0] pd, logic [7:0] m, logic [2:0] c,
                              logic [31:0] ep, logic [31:0] vc);
    vec_t v;
    v.rst = r;  v.irq = i;  v.fb = f;    v.ack = a;  v.rfe = e;   v.pc = p;
    v.mwe = mw; v.mwd = md; v.req = q;   v.svc = s;  v.pend = pd; v.mask = m;
    v.cause = c; v.epc = ep; v.vec = vc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
    else passed++;
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    rst = v.rst; irq = v.irq; fetch_bnd = v.fb; int_ack = v.ack; rfe = v.rfe;
    pc_in = v.pc; mask_we = v.mwe; mask_wdata = v.mwd;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    row++;
    chk("int_req",     32'(int_req),    32'(e.req));
    chk("in_service",  32'(in_service), 32'(e.svc));
    chk("pending",     32'(pending),    32'(e.pend));
    chk("mask_rdata",  32'(mask_rdata), 32'(e.mask));
    chk("cause",       32'(cause),      32'(e.cause));
    chk("epc",         epc,             e.epc);
    chk("vector_addr", vector_addr,     e.vec);
  endtask

  initial begin
    //            rst irq   fb ack rfe pc          mwe mwd    req svc pend  mask  c  epc         vec
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 32'h0,   32'h80));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 32'h0,   32'h80));
    // single edge source, ack two cycles after the boundary
    tbl.push_back(mk(0, 8'h08, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h08, 8'hFF, 0, 32'h0,   32'h80));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h08, 8'hFF, 0, 32'h0,   32'h80));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h08, 8'hFF, 0, 32'h0,   32'h80));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h140, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 3, 32'h140, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 3, 32'h140, 32'hB0));
    // two sources in one cycle: priority, then the loser after rfe
    tbl.push_back(mk(0, 8'h24, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h24, 8'hFF, 3, 32'h140, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h24, 8'hFF, 3, 32'h140, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h200, 0, 8'h00, 0, 1, 8'h20, 8'hFF, 2, 32'h200, 32'hA0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 0, 1, 8'h20, 8'hFF, 2, 32'h200, 32'hA0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0,   0, 8'h00, 0, 0, 8'h20, 8'hFF, 2, 32'h200, 32'hA0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h20, 8'hFF, 2, 32'h200, 32'hA0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h204, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 5, 32'h204, 32'hD0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 5, 32'h204, 32'hD0));
    // masked source stays pending, unmask raises it
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,   1, 8'hF7, 0, 0, 8'h00, 8'hF7, 5, 32'h204, 32'hD0));
    tbl.push_back(mk(0, 8'h08, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h08, 8'hF7, 5, 32'h204, 32'hD0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h08, 8'hF7, 5, 32'h204, 32'hD0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,   1, 8'hFF, 0, 0, 8'h08, 8'hFF, 5, 32'h204, 32'hD0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h08, 8'hFF, 5, 32'h204, 32'hD0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h300, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 3, 32'h300, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 3, 32'h300, 32'hB0));
    // level source drops before ack; late ack ignored
    tbl.push_back(mk(0, 8'h02, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h02, 8'hFF, 3, 32'h300, 32'hB0));
    tbl.push_back(mk(0, 8'h02, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h02, 8'hFF, 3, 32'h300, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h00, 8'hFF, 3, 32'h300, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 3, 32'h300, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h400, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 3, 32'h300, 32'hB0));
    // reset in SERVICE with a pending source and a modified mask
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h01, 8'hFF, 3, 32'h300, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h01, 8'hFF, 3, 32'h300, 32'hB0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h500, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 32'h500, 32'h80));
    tbl.push_back(mk(0, 8'h10, 0, 0, 0, 32'h0,   0, 8'h00, 0, 1, 8'h10, 8'hFF, 0, 32'h500, 32'h80));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 32'h0,   1, 8'h0F, 0, 1, 8'h10, 8'h0F, 0, 32'h500, 32'h80));
    tbl.push_back(mk(1, 8'h00, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 32'h0,   32'h80));
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h01, 8'hFF, 0, 32'h0,   32'h80));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h01, 8'hFF, 0, 32'h0,   32'h80));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 32'h600, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 0, 32'h600, 32'h80));
    tbl.push_back(mk(0, 8'h00, 0, 0, 1, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 0, 32'h600, 32'h80));

    foreach (tbl[k]) apply(tbl[k]);

    // Higher-priority source arriving during REQ takes the ack.
    apply(mk(0, 8'h40, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h40, 8'hFF, 0, 32'h600, 32'h80));
    apply(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h40, 8'hFF, 0, 32'h600, 32'h80));
    apply(mk(0, 8'h01, 0, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h41, 8'hFF, 0, 32'h600, 32'h80));
    apply(mk(0, 8'h00, 0, 1, 0, 32'h700, 0, 8'h00, 0, 1, 8'h40, 8'hFF, 0, 32'h700, 32'h80));
    apply(mk(0, 8'h00, 0, 0, 1, 32'h0,   0, 8'h00, 0, 0, 8'h40, 8'hFF, 0, 32'h700, 32'h80));
    apply(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h40, 8'hFF, 0, 32'h700, 32'h80));
    apply(mk(0, 8'h00, 0, 1, 0, 32'h704, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 6, 32'h704, 32'hE0));
    apply(mk(0, 8'h00, 0, 0, 1, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 6, 32'h704, 32'hE0));

    // Mask cleared during REQ makes the ack spurious; state captures are kept.
    apply(mk(0, 8'h08, 0, 0, 0, 32'h0,   0, 8'h00, 0, 0, 8'h08, 8'hFF, 6, 32'h704, 32'hE0));
    apply(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h08, 8'hFF, 6, 32'h704, 32'hE0));
    apply(mk(0, 8'h00, 0, 0, 0, 32'h0,   1, 8'h00, 1, 0, 8'h08, 8'h00, 6, 32'h704, 32'hE0));
    apply(mk(0, 8'h00, 0, 1, 0, 32'h800, 0, 8'h00, 0, 0, 8'h08, 8'h00, 6, 32'h704, 32'hE0));
    apply(mk(0, 8'h00, 0, 0, 0, 32'h0,   1, 8'hFF, 0, 0, 8'h08, 8'hFF, 6, 32'h704, 32'hE0));
    apply(mk(0, 8'h00, 1, 0, 0, 32'h0,   0, 8'h00, 1, 0, 8'h08, 8'hFF, 6, 32'h704, 32'hE0));
    apply(mk(0, 8'h00, 0, 1, 0, 32'h804, 0, 8'h00, 0, 1, 8'h00, 8'hFF, 3, 32'h804, 32'hB0));
    apply(mk(0, 8'h00, 0, 0, 1, 32'h0,   0, 8'h00, 0, 0, 8'h00, 8'hFF, 3, 32'h804, 32'hB0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised multi-source interrupt controller feeding the multicycle control FSM.
- Replaces the single `int_sig` / `int_en` scheme with N maskable sources, a fixed priority, per-source edge or level mode, a registered request/acknowledge handshake, EPC capture, a cause index and a per-source vector address.
- The control FSM samples `int_req` at instruction boundaries, pulses `int_ack` in its interrupt state, and pulses `rfe` on return-from-exception.

Parameters:
- N_IRQ, 8, number of interrupt sources (1..32).
- ADDR_W, 32, PC / vector width.
- VEC_BASE, 32'h0000_0080, vector address of source 0.
- VEC_SHIFT, 4, log2 of byte spacing between vectors.
- EDGE_MODE, {N_IRQ{1'b1}}, per-source mode: 1 = rising-edge, 0 = level.
- MASK_RST, {N_IRQ{1'b1}}, mask register reset value (1 = enabled).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- irq  in  N_IRQ  source lines, synchronous to clk
- fetch_bnd  in  1  control FSM is in FETCH (instruction boundary)
- int_ack  in  1  control FSM has entered its interrupt state (1-cycle pulse)
- rfe  in  1  RFE executed (1-cycle pulse)
- pc_in  in  ADDR_W  PC of the instruction about to be fetched
- mask_we  in  1  mask register write enable
- mask_wdata  in  N_IRQ  new mask value
- int_req  out  1  interrupt request to control FSM
- vector_addr  out  ADDR_W  handler address; valid from ack+1
- epc  out  ADDR_W  saved PC, selected by the FSM on RFE
- cause  out  CW  index of the serviced source, CW = max(1, clog2(N_IRQ))
- mask_rdata  out  N_IRQ  current mask register
- in_service  out  1  handler active (ie = 0)
- pending  out  N_IRQ  pending register, for debug/readback

Behaviour:
- Reset values:
  - `int_req` = 0, `pending` = 0, `epc` = 0, `cause` = 0, `in_service` = 0.
  - mask = MASK_RST; ie = 1.
  - `vector_addr` = VEC_BASE.
  - Edge detector history = 0.
  - state = IDLE.
- Source capture, every cycle:
  - Edge source i: pending[i] is set on irq[i] & ~irq_d[i].
  - Level source i: pending[i] = irq[i], one-cycle registered.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- active = pending & mask. winner = lowest index in active (index 0 has highest priority), computed combinationally.
- FSM states:
  - IDLE:
    - If ie & |active & fetch_bnd: next state REQ, `int_req` <= 1 (registered, so 1-cycle latency from the boundary).
    - Otherwise stay in IDLE.
  - REQ, `int_req` held at 1:
    - If |active == 0 and no `int_ack` (level source dropped or mask cleared): `int_req` <= 0, next state IDLE.
    - If `int_ack` & |active:
      - epc <= pc_in; cause <= winner; vector_addr <= VEC_BASE + (winner << VEC_SHIFT).
      - Clear pending[winner] if the winner is an edge source.
      - ie <= 0; `int_req` <= 0; next state SERVICE.
    - If `int_ack` & ~|active: spurious ack. `int_req` <= 0, next state IDLE, epc/cause/vector unchanged.
    - The winner is re-evaluated on the ack cycle; a higher-priority source arriving during REQ wins.
  - SERVICE:
    - `in_service` = 1; no new requests (no nesting).
    - Pending continues to accumulate.
    - rfe: ie <= 1, next state IDLE; a pending source is requested at the next fetch_bnd.
- Ignored inputs:
  - `rfe` in IDLE or REQ: ignored.
  - `int_ack` in IDLE or SERVICE: ignored.
- Mask writes:
  - `mask_we` takes effect next cycle in any state.
  - Masking does not clear pending; unmasking a pending edge source raises it.
- Reset while in REQ or SERVICE returns every register to its reset value and discards pending.
- `vector_addr` arithmetic is modulo 2^ADDR_W.

Decomposition:
- Shared package `irq_pkg`:
  - state enum {IDLE, REQ, SERVICE}.
  - cause-width function CW.
  - Default VEC_BASE / VEC_SHIFT constants.
- Sub-module `irq_prio_enc` (N-input lowest-index-first priority encoder) outputs the winner index and an any-valid bit.
- Edge detection, pending, mask and FSM stay in `irq_ctrl`.

Test Plan:
1. Reset, then idle 5 cycles -> `int_req` = 0, mask_rdata = 8'hFF, `in_service` = 0, `vector_addr` = 32'h80.
2. Edge pulse on irq[3]; fetch_bnd at t; `int_ack` at t+2 with pc_in = 32'h0000_0140 -> `int_req` = 1 at t+1; after ack: epc = 32'h140, cause = 3, vector_addr = 32'hB0, pending[3] = 0, `in_service` = 1.
3. irq[5] and irq[2] rise in the same cycle, then ack -> cause = 2, pending = 8'h20; after `rfe` and the next fetch_bnd, a second request is serviced with cause = 5.
4. mask_wdata = 8'hF7, then irq[3] pulses -> no `int_req`, pending[3] = 1; write 8'hFF -> `int_req` asserts at the next fetch_bnd + 1.
5. Level source (EDGE_MODE bit 1 = 0): irq[1] high, `int_req` rises, irq[1] drops before ack -> `int_req` falls, state IDLE; a late ack is ignored and epc is unchanged.
6. `rst` asserted in SERVICE with pending = 8'h10 -> next cycle pending = 0, `in_service` = 0, mask = 8'hFF; a new irq[0] is serviced normally.
